trdb_branch_map: RTL
====================

// Module: trdb_branch_map
// PURPOSE
// - Accumulates the taken/not-taken outcome of every retired conditional branch since the last emitted packet.
// - Provides the this-cycle branch-map view: the registered history plus the branch retiring this cycle.
// - Drives the empty/full inputs of trdb_priority.
// - On flush (packet emitted this cycle) the consumed history is discarded and accumulation restarts.
// PARAMETERS
// - NUM_BRANCHES  31  max branches per map; sets map width and the full threshold
// - CNT_W  $clog2(NUM_BRANCHES+1)  width of the branch counter (5 for default)
// PORTS
// - clk_i  in  1  clock
// - rst_ni  in  1  asynchronous active-low reset
// - valid_i  in  1  instruction retired this cycle; all other inputs ignored when 0
// - branch_i  in  1  retired instruction is a conditional branch
// - branch_taken_i  in  1  that branch was taken
// - flush_i  in  1  trdb_priority emitted a packet consuming the current view
// - map_o  out  NUM_BRANCHES  this-cycle map; bit i = branch i (oldest at 0); 0 = taken, 1 = not taken
// - branches_o  out  CNT_W  this-cycle branch count, 0..NUM_BRANCHES
// - is_empty_o  out  1  branches_o == 0, to tc_branch_map_empty_i
// - is_full_o  out  1  branches_o == NUM_BRANCHES, to tc_branch_map_full_i
// - overflow_o  out  1  sticky error: a branch arrived with the registered map already full
// BEHAVIOUR
// - Reset:
//   - map_q = 0, cnt_q = 0, overflow_q = 0.
//   - Therefore map_o = 0, branches_o = 0, is_empty_o = 1, is_full_o = 0, overflow_o = 0.
// - add = valid_i & branch_i & (cnt_q < NUM_BRANCHES).
// - View is combinational (zero latency) from state and this-cycle inputs:
//   - map_o = map_q with bit[cnt_q] = ~branch_taken_i when add is set.
//   - branches_o = cnt_q + add.
//   - is_empty_o and is_full_o are derived from branches_o.
// - Next state, evaluated in priority order:
//   - valid_i & flush_i: map_q <= 0, cnt_q <= 0. The current branch is consumed by the emitted packet.
//   - valid_i & ~flush_i: map_q <= map_o, cnt_q <= branches_o.
//   - ~valid_i: state holds. flush_i is ignored.
// - Bits of map_q at index >= cnt_q are always 0. Consumers may read map_o unmasked.
// - Full:
//   - A branch that makes branches_o == NUM_BRANCHES raises is_full_o in the same cycle.
//   - trdb_priority is expected to flush in that cycle.
//   - If cnt_q == NUM_BRANCHES and a branch arrives: add = 0, the branch is dropped, overflow_q <= 1.
//   - overflow_q clears only on reset.
//   - If flush_i is asserted in that same cycle, the flush still clears the map.
// - Non-branch retirement (valid_i & ~branch_i): the view equals the registered state; flush still clears it.
// - Counter arithmetic never wraps; cnt_q saturates at NUM_BRANCHES.
// - Reset asserted mid-operation clears all state immediately. No history survives reset.
// TESTING
// - Reset, then idle: map_o = 0, branches_o = 0, is_empty_o = 1, is_full_o = 0, overflow_o = 0.
// - Retire branches taken, not-taken, taken with no flush:
//   - cycle 3 view shows map_o[2:0] = 3'b010 and branches_o = 3.
//   - is_empty_o falls in the cycle of the first branch.
// - 31 consecutive not-taken branches:
//   - on the 31st, is_full_o = 1 and map_o = 31'h7FFFFFFF in the same cycle.
//   - with flush_i = 1 that cycle, the next cycle shows branches_o = 0, is_empty_o = 1.
// - Fill to 31 without flush, then one more branch:
//   - overflow_o rises the following cycle and branches_o stays 31.
//   - a later flush clears the map but overflow_o stays 1 until reset.
// - 2 branches stored, then a branch with flush_i = 1:
//   - that cycle branches_o = 3, map_o bit2 reflects the new branch.
//   - next cycle branches_o = 0.
// - valid_i = 0 with branch_i = 1 and flush_i = 1: state unchanged.
//   - rst_ni pulsed low asynchronously with 5 branches stored clears the view before the next clock edge.

Source files
------------

// File: rtl/trdb_branch_map.sv
// Branch-map accumulator: records taken/not-taken of retired conditional branches
// since the last emitted packet and exposes a zero-latency view including this cycle's branch.
module trdb_branch_map #(
    parameter int unsigned NUM_BRANCHES = 31,
    parameter int unsigned CNT_W        = $clog2(NUM_BRANCHES + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    valid_i,
    input  logic                    branch_i,
    input  logic                    branch_taken_i,
    input  logic                    flush_i,
    output logic [NUM_BRANCHES-1:0] map_o,
    output logic [CNT_W-1:0]        branches_o,
    output logic                    is_empty_o,
    output logic                    is_full_o,
    output logic                    overflow_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_BRANCHES);

    logic [NUM_BRANCHES-1:0] map_q, map_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    overflow_q, overflow_d;

    logic                    is_branch;
    logic                    add;
    logic [NUM_BRANCHES-1:0] map_view;
    logic [CNT_W-1:0]        cnt_view;

    assign is_branch = valid_i & branch_i;
    assign add       = is_branch & (cnt_q < MAX_CNT);

    // The new branch lands at slot cnt_q; slots above cnt_q are already zero.
    always_comb begin
        map_view = map_q;
        for (int unsigned i = 0; i < NUM_BRANCHES; i++) begin
            if (add && (cnt_q == CNT_W'(i))) begin
                map_view[i] = ~branch_taken_i;
            end
        end
        cnt_view = cnt_q + CNT_W'(add);
    end

    always_comb begin
        map_d      = map_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q | (is_branch & (cnt_q == MAX_CNT));
        if (valid_i) begin
            if (flush_i) begin
                map_d = '0;
                cnt_d = '0;
            end else begin
                map_d = map_view;
                cnt_d = cnt_view;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            map_q      <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            map_q      <= map_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign map_o      = map_view;
    assign branches_o = cnt_view;
    assign is_empty_o = (cnt_view == '0);
    assign is_full_o  = (cnt_view == MAX_CNT);
    assign overflow_o = overflow_q;

endmodule
